// File: rtl/bus_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM responder.
// Holds the bus widths, the default SRAM word-address width, the wait-counter
// width and the responder state encoding.
package bus_pkg;

  localparam int unsigned WB_DATA_W   = 32;
  localparam int unsigned WB_SEL_W    = 4;
  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned WAIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    ACK    = 3'd4
  } state_e;

endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte-lane merge for read-modify-write.
// Ports:
//   old_data  word read back from the SRAM
//   new_data  latched bus write data
//   sel       byte lanes taken from new_data (bit n -> bits [8n+7:8n])
//   merged_c  merged word
module wb_byte_merge
  import bus_pkg::*;
(
  input  logic [WB_DATA_W-1:0] old_data,
  input  logic [WB_DATA_W-1:0] new_data,
  input  logic [WB_SEL_W-1:0]  sel,
  output logic [WB_DATA_W-1:0] merged_c
);

  // Lanes with sel set come from the bus, the rest keep the SRAM contents.
  always_comb begin
    merged_c = old_data;
    for (int n = 0; n < int'(WB_SEL_W); n++) begin
      if (sel[n]) begin
        merged_c[8*n +: 8] = new_data[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle responder driving one asynchronous 32-bit SRAM bank.
// One bus request becomes timed SRAM read/write phases of WAIT_CYCLES each.
// Optional feature macro: WB_SRAM_RMW_EN -- when defined, partial byte-select
// writes are done as read-modify-write; otherwise any non-zero select writes
// the full word.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wishbone_*_i        Wishbone request (cyc, stb, we, addr, select, data)
//   wishbone_data_o     registered read data, held until the next read
//   wishbone_ack_o      acknowledge, gated by cyc & stb
//   ram_addr            SRAM word address
//   ram_data            SRAM bidirectional data bus
//   ram_ce/oe/we        SRAM strobes, active low
module wb_sram_responder
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = SRAM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wishbone_cyc_i,
  input  logic                 wishbone_stb_i,
  input  logic                 wishbone_we_i,
  input  logic [31:0]          wishbone_addr_i,
  input  logic [WB_SEL_W-1:0]  wishbone_select_i,
  input  logic [WB_DATA_W-1:0] wishbone_data_i,
  output logic [WB_DATA_W-1:0] wishbone_data_o,
  output logic                 wishbone_ack_o,
  output logic [ADDR_W-1:0]    ram_addr,
  inout  wire  [WB_DATA_W-1:0] ram_data,
  output logic                 ram_ce,
  output logic                 ram_oe,
  output logic                 ram_we
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                 state_q, state_n;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_n;
  logic [WB_DATA_W-1:0]   word_q;
  logic                   drive_q;
  logic                   accept_c;
  logic                   rd_done_c;
  logic                   turn_n;
  logic                   ce_n, oe_n, we_n, drive_n;

  // Byte-offset and aliased upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wishbone_addr_i[1:0], wishbone_addr_i[31:ADDR_W+2]};

`ifdef WB_SRAM_RMW_EN
  logic [WB_SEL_W-1:0]  sel_q;
  logic [WB_DATA_W-1:0] merged_c;
  logic                 merge_load_c;

  wb_byte_merge u_merge (
    .old_data (ram_data),
    .new_data (word_q),
    .sel      (sel_q),
    .merged_c (merged_c)
  );
`endif

  // Next-state, phase counter and strobe decode for the state being entered.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    turn_n    = 1'b0;
    accept_c  = 1'b0;
    rd_done_c = 1'b0;
`ifdef WB_SRAM_RMW_EN
    merge_load_c = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (wishbone_cyc_i && wishbone_stb_i) begin
          accept_c = 1'b1;
          cnt_n    = WAIT_LOAD;
          if (!wishbone_we_i) begin
            state_n = RD;
          end else if (wishbone_select_i == '0) begin
            state_n = ACK;
`ifdef WB_SRAM_RMW_EN
          end else if (wishbone_select_i != '1) begin
            state_n = RMW_RD;
`endif
          end else begin
            state_n = WR;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rd_done_c = 1'b1;
          state_n   = ACK;
        end else begin
          cnt_n = cnt_q - WAIT_CNT_W'(1);
        end
      end
`ifdef WB_SRAM_RMW_EN
      RMW_RD: begin
        if (cnt_q == '0) begin
          merge_load_c = 1'b1;
          turn_n       = 1'b1;
          cnt_n        = WAIT_LOAD;
          state_n      = WR;
        end else begin
          cnt_n = cnt_q - WAIT_CNT_W'(1);
        end
      end
`endif
      WR: begin
        if (cnt_q == '0) begin
          state_n = ACK;
        end else begin
          cnt_n = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Strobes are registered, so decode them from the upcoming state.
    ce_n    = 1'b1;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    drive_n = 1'b0;
    case (state_n)
      RD, RMW_RD: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
      end
      WR: begin
        // The first WR cycle after a read-back is a bus turnaround.
        ce_n    = 1'b0;
        we_n    = turn_n;
        drive_n = !turn_n;
      end
      ACK: begin
        // Hold write data one cycle past the rising edge of we.
        drive_n = (state_q == WR);
      end
      default: begin
      end
    endcase
  end

  // State, strobes, latched request and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ram_ce          <= 1'b1;
      ram_oe          <= 1'b1;
      ram_we          <= 1'b1;
      drive_q         <= 1'b0;
      ram_addr        <= '0;
      word_q          <= '0;
      wishbone_data_o <= '0;
`ifdef WB_SRAM_RMW_EN
      sel_q           <= '0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ram_ce  <= ce_n;
      ram_oe  <= oe_n;
      ram_we  <= we_n;
      drive_q <= drive_n;
      if (accept_c) begin
        ram_addr <= wishbone_addr_i[ADDR_W+1:2];
        word_q   <= wishbone_data_i;
`ifdef WB_SRAM_RMW_EN
        sel_q    <= wishbone_select_i;
`endif
      end
      if (rd_done_c) begin
        wishbone_data_o <= ram_data;
      end
`ifdef WB_SRAM_RMW_EN
      if (merge_load_c) begin
        word_q <= merged_c;
      end
`endif
    end
  end

  assign ram_data       = drive_q ? word_q : {WB_DATA_W{1'bz}};
  assign wishbone_ack_o = (state_q == ACK) && wishbone_cyc_i && wishbone_stb_i;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: directed vector table, hand
// sequences for reset/abort/back-to-back corners, and randomized transfers
// against a word-array reference model.
module tb_wb_sram_responder;

  localparam int unsigned WAIT = 2;
  localparam int unsigned AW   = 20;
`ifdef WB_SRAM_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [31:0]   addr, wdata;
  logic [3:0]    sel;
  logic [31:0]   data_o;
  logic          ack;
  logic [AW-1:0] ram_addr;
  wire  [31:0]   ram_data;
  logic          ram_ce, ram_oe, ram_we;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  logic [31:0] sram  [0:1023];
  logic [31:0] model [0:15];
  logic [31:0] last_rd;
  logic        clr_mem;

  always #5 clk = ~clk;

  wb_sram_responder #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wishbone_cyc_i    (cyc),
    .wishbone_stb_i    (stb),
    .wishbone_we_i     (we),
    .wishbone_addr_i   (addr),
    .wishbone_select_i (sel),
    .wishbone_data_i   (wdata),
    .wishbone_data_o   (data_o),
    .wishbone_ack_o    (ack),
    .ram_addr          (ram_addr),
    .ram_data          (ram_data),
    .ram_ce            (ram_ce),
    .ram_oe            (ram_oe),
    .ram_we            (ram_we)
  );

  // Asynchronous SRAM model: drives on ce&oe, stores mid-cycle on ce&we.
  assign ram_data = (!ram_ce && !ram_oe) ? sram[ram_addr[9:0]] : 32'bz;

  always @(negedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
    end else if (!ram_ce && !ram_we) begin
      sram[ram_addr[9:0]] <= ram_data;
    end
  end

  // Output enable and write enable must never be low together.
  always @(negedge clk) begin
    if (!ram_oe && !ram_we) viol <= viol + 1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected behaviour from the transfer rules.
  function automatic int exp_lat(input logic w, input logic [3:0] s);
    if (!w) return WAIT + 1;
    if (s == 4'h0) return 1;
    if (RMW && s != 4'hF) return 2 * WAIT + 1;
    return WAIT + 1;
  endfunction

  function automatic int exp_ce_lo(input logic w, input logic [3:0] s);
    if (!w) return WAIT;
    if (s == 4'h0) return 0;
    if (RMW && s != 4'hF) return 2 * WAIT;
    return WAIT;
  endfunction

  function automatic int exp_we_lo(input logic w, input logic [3:0] s);
    if (!w || s == 4'h0) return 0;
    if (RMW && s != 4'hF) return WAIT - 1;
    return WAIT;
  endfunction

  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
    logic [31:0] mask;
    if (s == 4'h0) return old;
    if (!RMW) return nw;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  // One Wishbone transfer; inputs are scrambled after acceptance.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output int lat, output int ce_lo, output int we_lo,
                      output logic [AW-1:0] seen_addr);
    bit got;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(posedge clk); #1;
    addr = ~a; wdata = ~d; sel = ~s; we = ~w;
    lat = 0; ce_lo = 0; we_lo = 0; seen_addr = '0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (!ram_ce) begin ce_lo++; seen_addr = ram_addr; end
      if (!ram_we) we_lo++;
      if (ack) got = 1'b1;
    end
    if (!got) lat = 999;
    rd = data_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Run a transfer and check it against the expectations and model.
  task automatic run_and_check(input string tag, input logic w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d,
                               input logic [31:0] exp_rd, input logic [AW-1:0] exp_addr);
    logic [31:0] rd;
    int lat, ce_lo, we_lo;
    logic [AW-1:0] seen;
    xfer(w, a, s, d, rd, lat, ce_lo, we_lo, seen);
    check_int({tag, " latency"}, lat, exp_lat(w, s));
    check_int({tag, " ce_low_cycles"}, ce_lo, exp_ce_lo(w, s));
    check_int({tag, " we_low_cycles"}, we_lo, exp_we_lo(w, s));
    if (exp_ce_lo(w, s) > 0) check32({tag, " ram_addr"}, 32'(seen), 32'(exp_addr));
    if (!w) begin
      check32({tag, " read_data"}, rd, exp_rd);
      last_rd = exp_rd;
    end else begin
      check32({tag, " data_o_held"}, rd, last_rd);
      if (a[31:6] == 26'h0 || a[21:6] == 16'h0) model[a[5:2]] = apply_write(model[a[5:2]], d, s);
    end
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [19:0] exp_addr;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    logic [31:0] rd, a, d;
    logic [3:0]  s;
    logic        w;
    int          lat, ce_lo, we_lo, n, ack_cnt, oe_cnt, idx, r;
    logic [AW-1:0] seen;
    bit          done;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; last_rd = '0; clr_mem = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset ram_ce", int'(ram_ce), 1);
    check_int("reset ram_oe", int'(ram_oe), 1);
    check_int("reset ram_we", int'(ram_we), 1);
    check32("reset ram_addr", 32'(ram_addr), 32'h0);
    check32("reset data_o", data_o, 32'h0);
    check_int("reset ack", int'(ack), 0);
    @(posedge clk); #1;
    rst = 1'b0; clr_mem = 1'b0;

    // Reset in the middle of a write phase.
    run_and_check("pre_reset_wr", 1'b1, 32'h34, 4'hF, 32'h600DF00D, 32'h0, 20'hD);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; wdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_int("midwr we_low_before_reset", int'(ram_we), 0);
    @(negedge clk);
    check_int("midwr ram_ce", int'(ram_ce), 1);
    check_int("midwr ram_oe", int'(ram_oe), 1);
    check_int("midwr ram_we", int'(ram_we), 1);
    check_int("midwr ack", int'(ack), 0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    run_and_check("post_reset_rd", 1'b0, 32'h34, 4'h0, 32'h0, 32'h600DF00D, 20'hD);

    // Directed vector table.
    vecs[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0, 20'h4};
    vecs[1] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEADBEEF, 20'h4};
    vecs[2] = '{1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 32'h0, 20'h8};
    vecs[3] = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABBCCDD, 32'h0, 20'h8};
    vecs[4] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0, RMW ? 32'h11BB33DD : 32'hAABBCCDD, 20'h8};
    vecs[5] = '{1'b1, 32'h0000_0020, 4'h0, 32'h12345678, 32'h0, 20'h8};
    vecs[6] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0, RMW ? 32'h11BB33DD : 32'hAABBCCDD, 20'h8};
    vecs[7] = '{1'b1, 32'h0000_0008, 4'hF, 32'hCAFEF00D, 32'h0, 20'h2};
    vecs[8] = '{1'b0, 32'h0040_0008, 4'h0, 32'h0, 32'hCAFEF00D, 20'h2};
    vecs[9] = '{1'b0, 32'hFFC0_0013, 4'h0, 32'h0, 32'hDEADBEEF, 20'h4};
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d,
                    vecs[i].exp_rd, vecs[i].exp_addr);
    end

    // Master drops cyc during the first read cycle.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    ack_cnt = 0; oe_cnt = 0;
    for (int i = 0; i < WAIT + 4; i++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
      if (!ram_oe) oe_cnt++;
    end
    check_int("abort ack_count", ack_cnt, 0);
    check_int("abort oe_low_cycles", oe_cnt, WAIT);
    check32("abort data_o", data_o, model[4]);
    last_rd = model[4];
    run_and_check("after_abort_rd", 1'b0, 32'h20, 4'h0, 32'h0, model[8], 20'h8);

    // Back-to-back reads with cyc held: exactly one IDLE cycle between them.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h08;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ack) done = 1'b1;
    end
    check_int("b2b first_ack", int'(done), 1);
    n = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n++;
      if (!ram_oe) done = 1'b1;
    end
    check_int("b2b cycles_to_next_rd", n, 2);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ack) done = 1'b1;
    end
    check_int("b2b second_ack", int'(done), 1);
    check32("b2b data", data_o, model[2]);
    last_rd = model[2];
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;

    // Randomized transfers against the word model, with aliased upper bits.
    for (int i = 0; i < 150; i++) begin
      idx = int'($urandom_range(15));
      a = (32'($urandom_range(1023)) << 22) | (32'(idx) << 2) | 32'($urandom_range(3));
      w = 1'($urandom_range(1));
      r = int'($urandom_range(5));
      s = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(15));
      d = $urandom;
      xfer(w, a, s, d, rd, lat, ce_lo, we_lo, seen);
      check_int($sformatf("rand%0d latency", i), lat, exp_lat(w, s));
      check_int($sformatf("rand%0d we_low_cycles", i), we_lo, exp_we_lo(w, s));
      if (exp_ce_lo(w, s) > 0) check32($sformatf("rand%0d ram_addr", i), 32'(seen), 32'(idx));
      if (!w) begin
        check32($sformatf("rand%0d read_data", i), rd, model[idx]);
        last_rd = model[idx];
      end else begin
        check32($sformatf("rand%0d data_o_held", i), rd, last_rd);
        model[idx] = apply_write(model[idx], d, s);
      end
    end

    // Final memory contents and strobe invariant.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      check32($sformatf("final_mem word%0d", i), sram[i], model[i]);
    end
    check_int("oe_we_overlap_cycles", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
